// File: rtl/cache_mshr_if.sv
// Bundle between the cache metadata stage, the MSHR file and the L2 port.
// Requests use valid/ready: a request transfers on a cycle where
// l2_req_valid and l2_req_ready are both high; while valid is high and
// ready is low the request fields hold steady. Fills have no back-pressure.
interface cache_mshr_if #(
    parameter int ADDR_W      = 26,
    parameter int NUM_ENTRIES = 4,
    parameter int WAY_W       = 4
);
    localparam int ID_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    // lookup from the metadata stage
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              mshr_hit;
    // miss allocation
    logic              alloc;
    logic [ADDR_W-1:0] alloc_addr;
    logic [WAY_W-1:0]  alloc_way;
    logic [2:0]        alloc_op;
    logic              full;
    logic [ID_W:0]     occupancy;
    // L2 request channel
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_addr;
    logic [2:0]        l2_req_op;
    logic [ID_W-1:0]   l2_req_id;
    // L2 fill response
    logic              l2_fill_valid;
    logic [ID_W-1:0]   l2_fill_id;
    // resolved miss back to the cache
    logic              fill_valid;
    logic [ADDR_W-1:0] fill_addr;
    logic [WAY_W-1:0]  fill_way;
    logic [2:0]        fill_op;

    // upstream stage and L2 model side
    modport master (
        output lookup_valid, lookup_addr, alloc, alloc_addr, alloc_way, alloc_op,
               l2_req_ready, l2_fill_valid, l2_fill_id,
        input  mshr_hit, full, occupancy, l2_req_valid, l2_req_addr, l2_req_op,
               l2_req_id, fill_valid, fill_addr, fill_way, fill_op
    );

    // MSHR file side
    modport slave (
        input  lookup_valid, lookup_addr, alloc, alloc_addr, alloc_way, alloc_op,
               l2_req_ready, l2_fill_valid, l2_fill_id,
        output mshr_hit, full, occupancy, l2_req_valid, l2_req_addr, l2_req_op,
               l2_req_id, fill_valid, fill_addr, fill_way, fill_op
    );
endinterface

// File: rtl/cache_mshr_file.sv
// Miss Status Holding Register file: tracks outstanding line misses, issues
// one L2 request per miss and returns resolved fills with their victim way.
// Each entry walks IDLE -> WAIT_ISSUE -> WAIT_FILL -> IDLE.
module cache_mshr_file #(
    parameter int ADDR_W      = 26,
    parameter int NUM_ENTRIES = 4,
    parameter int WAY_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_mshr_if.slave              bus,
    output logic [2*NUM_ENTRIES-1:0] dbg_state_o
);
    localparam int ID_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_ISSUE = 2'd1,
        S_WAIT_FILL  = 2'd2
    } state_e;

    state_e            state_q [NUM_ENTRIES];
    logic [ADDR_W-1:0] addr_q  [NUM_ENTRIES];
    logic [WAY_W-1:0]  way_q   [NUM_ENTRIES];
    logic [2:0]        op_q    [NUM_ENTRIES];

    // a stalled request pins its entry so a lower index cannot preempt it
    logic              lock_q;
    logic [ID_W-1:0]   lock_id_q;

    logic              fill_valid_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [WAY_W-1:0]  fill_way_q;
    logic [2:0]        fill_op_q;

    logic              alloc_found;
    logic [ID_W-1:0]   alloc_idx;
    logic              alloc_en;
    logic              issue_any;
    logic [ID_W-1:0]   issue_low;
    logic [ID_W-1:0]   issue_sel;
    logic              issue_fire;
    logic              fill_en;
    logic              hit;
    logic [ID_W:0]     occ;

    // Scan entries from the top down so the lowest index wins each search.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        issue_any   = 1'b0;
        issue_low   = '0;
        fill_en     = 1'b0;
        hit         = 1'b0;
        occ         = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == S_IDLE) begin
                alloc_found = 1'b1;
                alloc_idx   = ID_W'(i);
            end
            if (state_q[i] == S_WAIT_ISSUE) begin
                issue_any = 1'b1;
                issue_low = ID_W'(i);
            end
            if (state_q[i] != S_IDLE) begin
                occ = occ + (ID_W + 1)'(1);
                if (bus.lookup_valid && (addr_q[i] == bus.lookup_addr)) begin
                    hit = 1'b1;
                end
            end
            if (bus.l2_fill_valid && (bus.l2_fill_id == ID_W'(i)) &&
                (state_q[i] == S_WAIT_FILL)) begin
                fill_en = 1'b1;
            end
        end
    end

    assign alloc_en   = bus.alloc && alloc_found &&
                        ((bus.alloc_op == 3'd1) || (bus.alloc_op == 3'd2));
    assign issue_sel  = lock_q ? lock_id_q : issue_low;
    assign issue_fire = issue_any && bus.l2_req_ready;

    assign bus.mshr_hit     = hit;
    assign bus.full         = !alloc_found;
    assign bus.occupancy    = occ;
    assign bus.l2_req_valid = issue_any;
    assign bus.l2_req_addr  = addr_q[issue_sel];
    assign bus.l2_req_op    = (op_q[issue_sel] == 3'd2) ? 3'd7 : 3'd3;
    assign bus.l2_req_id    = issue_sel;
    assign bus.fill_valid   = fill_valid_q;
    assign bus.fill_addr    = fill_addr_q;
    assign bus.fill_way     = fill_way_q;
    assign bus.fill_op      = fill_op_q;

    // Flatten per-entry state for observation.
    always_comb begin
        dbg_state_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            dbg_state_o[2*i +: 2] = state_q[i];
        end
    end

    // Entry state machines, request lock and registered fill response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= S_IDLE;
                addr_q[i]  <= '0;
                way_q[i]   <= '0;
                op_q[i]    <= '0;
            end
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_way_q   <= '0;
            fill_op_q    <= '0;
        end else begin
            // alloc, issue and fill always target entries in distinct states
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc_en && (alloc_idx == ID_W'(i))) begin
                    state_q[i] <= S_WAIT_ISSUE;
                    addr_q[i]  <= bus.alloc_addr;
                    way_q[i]   <= bus.alloc_way;
                    op_q[i]    <= bus.alloc_op;
                end else if (issue_fire && (issue_sel == ID_W'(i))) begin
                    state_q[i] <= S_WAIT_FILL;
                end else if (fill_en && (bus.l2_fill_id == ID_W'(i))) begin
                    state_q[i] <= S_IDLE;
                end
            end
            if (issue_any && !bus.l2_req_ready) begin
                lock_q    <= 1'b1;
                lock_id_q <= issue_sel;
            end else begin
                lock_q    <= 1'b0;
            end
            fill_valid_q <= fill_en;
            if (fill_en) begin
                fill_addr_q <= addr_q[bus.l2_fill_id];
                fill_way_q  <= way_q[bus.l2_fill_id];
                fill_op_q   <= op_q[bus.l2_fill_id];
            end
        end
    end
endmodule

// File: tb/tb_cache_mshr_file.sv
// Bench for cache_mshr_file: directed walk through the miss lifecycle, then
// random traffic, each cycle checked against a behavioural MSHR model.
module tb_cache_mshr_file;
    localparam int ADDR_W      = 26;
    localparam int NUM_ENTRIES = 4;
    localparam int WAY_W       = 4;
    localparam int ID_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int SW          = 1 + ADDR_W + 3 + ID_W + 1 + 1 + (ID_W + 1) + 1;
    localparam int FW          = ADDR_W + WAY_W + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2*NUM_ENTRIES-1:0] dbg_state;

    cache_mshr_if #(.ADDR_W(ADDR_W), .NUM_ENTRIES(NUM_ENTRIES), .WAY_W(WAY_W)) bus_if ();

    cache_mshr_file #(.ADDR_W(ADDR_W), .NUM_ENTRIES(NUM_ENTRIES), .WAY_W(WAY_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [SW-1:0] stat_q[$];
    logic [FW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model: per-entry lifecycle stage (0 free, 1 awaiting issue,
    // 2 awaiting fill), stored miss info, the pinned request and the fill reg
    int                m_stage [NUM_ENTRIES];
    logic [ADDR_W-1:0] m_addr  [NUM_ENTRIES];
    logic [WAY_W-1:0]  m_way   [NUM_ENTRIES];
    logic [2:0]        m_op    [NUM_ENTRIES];
    int                m_pinned;
    logic              m_fv;

    logic [ADDR_W-1:0] addr_pool [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_ENTRIES; i++) m_stage[i] = 0;
        m_pinned = -1;
        m_fv     = 1'b0;
    endtask

    // driver: apply one cycle of inputs, queue expectations, advance the model
    task automatic drive_cycle(input logic r, input logic lv, input logic [ADDR_W-1:0] la,
                               input logic al, input logic [ADDR_W-1:0] aa,
                               input logic [WAY_W-1:0] aw, input logic [2:0] ao,
                               input logic rdy, input logic fv, input logic [ID_W-1:0] fid);
        int cnt, low_wait, low_free, sel;
        logic e_hit;
        logic [ADDR_W-1:0] e_addr;
        logic [2:0] e_op;
        logic [ID_W-1:0] e_id;
        @(negedge clk);
        rst                  = r;
        bus_if.lookup_valid  = lv;
        bus_if.lookup_addr   = la;
        bus_if.alloc         = al;
        bus_if.alloc_addr    = aa;
        bus_if.alloc_way     = aw;
        bus_if.alloc_op      = ao;
        bus_if.l2_req_ready  = rdy;
        bus_if.l2_fill_valid = fv;
        bus_if.l2_fill_id    = fid;
        #1;
        cnt = 0; e_hit = 1'b0; low_wait = -1; low_free = -1;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (m_stage[i] != 0) begin
                cnt++;
                if (lv && m_addr[i] == la) e_hit = 1'b1;
            end
            if (m_stage[i] == 1 && low_wait < 0) low_wait = i;
            if (m_stage[i] == 0 && low_free < 0) low_free = i;
        end
        sel = (m_pinned >= 0) ? m_pinned : low_wait;
        e_addr = '0; e_op = '0; e_id = '0;
        if (sel >= 0) begin
            e_addr = m_addr[sel];
            e_op   = (m_op[sel] == 3'd1) ? 3'd3 : 3'd7;
            e_id   = ID_W'(sel);
        end
        stat_q.push_back({sel >= 0, e_addr, e_op, e_id, e_hit, cnt == NUM_ENTRIES,
                          (ID_W + 1)'(cnt), m_fv});
        if (r) begin
            m_reset();
        end else begin
            if (fv && m_stage[fid] == 2) begin
                m_fv = 1'b1;
                exp_q.push_back({m_addr[fid], m_way[fid], m_op[fid]});
                m_stage[fid] = 0;
            end else begin
                m_fv = 1'b0;
            end
            if (sel >= 0) begin
                if (rdy) begin
                    m_stage[sel] = 2;
                    m_pinned = -1;
                end else begin
                    m_pinned = sel;
                end
            end
            if (al && low_free >= 0 && (ao == 3'd1 || ao == 3'd2)) begin
                m_stage[low_free] = 1;
                m_addr[low_free]  = aa;
                m_way[low_free]   = aw;
                m_op[low_free]    = ao;
            end
        end
    endtask

    // monitor: compare status every cycle, pop a fill whenever the DUT shows one
    initial begin
        logic [SW-1:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (stat_q.size() > 0) begin
                act = {bus_if.l2_req_valid,
                       bus_if.l2_req_valid ? bus_if.l2_req_addr : {ADDR_W{1'b0}},
                       bus_if.l2_req_valid ? bus_if.l2_req_op : 3'd0,
                       bus_if.l2_req_valid ? bus_if.l2_req_id : {ID_W{1'b0}},
                       bus_if.mshr_hit, bus_if.full, bus_if.occupancy, bus_if.fill_valid};
                check("status", 64'(act), 64'(stat_q.pop_front()));
                if (bus_if.fill_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL fill_unexpected: got addr %h way %b op %0d, required no fill at %0t",
                                 bus_if.fill_addr, bus_if.fill_way, bus_if.fill_op, $time);
                    end else begin
                        check("fill", 64'({bus_if.fill_addr, bus_if.fill_way, bus_if.fill_op}),
                              64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // stimulus and final report
    initial begin
        addr_pool = '{26'h100, 26'h104, 26'h200, 26'h300, 26'h400, 26'h500, 26'h600, 26'h3ffffff};
        bus_if.lookup_valid  = 1'b0;
        bus_if.lookup_addr   = '0;
        bus_if.alloc         = 1'b0;
        bus_if.alloc_addr    = '0;
        bus_if.alloc_way     = '0;
        bus_if.alloc_op      = '0;
        bus_if.l2_req_ready  = 1'b0;
        bus_if.l2_fill_valid = 1'b0;
        bus_if.l2_fill_id    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_reset();

        // directed lifecycle
        drive_cycle(1, 0, 0,        0, 0,        0,       0, 0, 0, 0);
        drive_cycle(0, 0, 0,        1, 26'h100,  4'b0010, 1, 0, 0, 0);
        drive_cycle(0, 1, 26'h100,  0, 0,        0,       0, 0, 0, 0);
        drive_cycle(0, 1, 26'h104,  1, 26'h200,  4'b0100, 2, 0, 0, 0);
        repeat (4) drive_cycle(0, 1, 26'h200, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0,        0, 0,        0,       0, 1, 0, 0);
        drive_cycle(0, 0, 0,        0, 0,        0,       0, 1, 0, 0);
        drive_cycle(0, 0, 0,        1, 26'h300,  4'b0001, 1, 0, 0, 0);
        drive_cycle(0, 0, 0,        1, 26'h400,  4'b1000, 2, 0, 0, 0);
        drive_cycle(0, 1, 26'h500,  1, 26'h500,  4'b0001, 1, 0, 0, 0);
        drive_cycle(0, 1, 26'h500,  0, 0,        0,       0, 1, 0, 0);
        drive_cycle(0, 0, 0,        0, 0,        0,       0, 0, 1, 2'd3);
        drive_cycle(0, 0, 0,        1, 26'h600,  4'b0001, 1, 0, 1, 2'd2);
        drive_cycle(0, 1, 26'h600,  1, 26'h600,  4'b0001, 1, 0, 0, 0);
        drive_cycle(0, 1, 26'h600,  0, 0,        0,       0, 0, 0, 0);
        drive_cycle(1, 1, 26'h100,  1, 26'h700,  4'b0010, 1, 1, 1, 2'd1);
        drive_cycle(0, 1, 26'h100,  0, 0,        0,       0, 0, 1, 2'd0);
        drive_cycle(0, 0, 0,        0, 0,        0,       0, 0, 1, 2'd3);
        drive_cycle(0, 0, 0,        1, 26'h700,  4'b0010, 3, 0, 0, 0);
        drive_cycle(0, 1, 26'h700,  0, 0,        0,       0, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive_cycle($urandom_range(0, 99) == 0,
                        $urandom_range(0, 9) < 7, addr_pool[$urandom_range(0, 7)],
                        $urandom_range(0, 1) == 1, addr_pool[$urandom_range(0, 7)],
                        WAY_W'(1 << $urandom_range(0, WAY_W - 1)), 3'($urandom_range(0, 3)),
                        $urandom_range(0, 9) < 6,
                        $urandom_range(0, 9) < 4, ID_W'($urandom_range(0, NUM_ENTRIES - 1)));
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;

        n_checks++;
        if (stat_q.size() == 0 && exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d status and %0d fills left, required 0 and 0",
                      stat_q.size(), exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_mshr_file.md
Name: cache_mshr_file

Overview:
- Miss Status Holding Register file directly downstream of the cache metadata next-state stage.
- Consumes that stage's miss-allocation decision (mshr_alloc, way_out, operation) and returns mshr_hit to it.
- Tracks up to NUM_ENTRIES outstanding line misses, issues one L2 request per miss over a valid/ready handshake, and matches L2 fill responses back to the allocated way.

Parameters:
ADDR_W, 26, line-address width (byte offset already stripped)
NUM_ENTRIES, 4, number of MSHR entries; entry id width ID_W = clog2(NUM_ENTRIES), minimum 1
WAY_W, 4, width of one-hot way select

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
lookup_valid  in  1  pipeline lookup qualifier
lookup_addr  in  ADDR_W  line address being looked up
mshr_hit  out  1  lookup address matches a busy entry (combinational)
alloc  in  1  allocate request (driven by mshr_alloc)
alloc_addr  in  ADDR_W  line address of the miss
alloc_way  in  WAY_W  one-hot victim way (way_out)
alloc_op  in  3  cache operation; 1=LD, 2=ST
full  out  1  no IDLE entry exists
occupancy  out  ID_W+1  count of non-IDLE entries
l2_req_valid  out  1  L2 request valid
l2_req_ready  in  1  L2 accepts request
l2_req_addr  out  ADDR_W  request line address
l2_req_op  out  3  3=RD for LD, 7=RWITM for ST
l2_req_id  out  ID_W  issuing entry index
l2_fill_valid  in  1  L2 fill response valid (always accepted)
l2_fill_id  in  ID_W  entry index the fill completes
fill_valid  out  1  one-cycle pulse: miss resolved
fill_addr  out  ADDR_W  address of resolved entry
fill_way  out  WAY_W  way to write
fill_op  out  3  original alloc_op

Behaviour:
- Per-entry state machine: IDLE -> WAIT_ISSUE -> WAIT_FILL -> IDLE. Each entry holds addr, way, and op.
- Reset:
  - All entries go to IDLE.
  - fill_valid=0, l2_req_valid=0, full=0, occupancy=0, mshr_hit=0.
  - The reset is synchronous and overrides every other input in that cycle, including alloc and fill.
  - Any in-flight request is abandoned and any later fill for it is ignored.
- Allocation:
  - Condition: alloc=1 and full=0.
  - Takes the lowest-index IDLE entry (state sampled at the start of the cycle). That entry goes to WAIT_ISSUE at the edge.
  - alloc_op values other than 1 or 2 are ignored (no allocation).
  - alloc while full=1 is dropped silently; the upstream stage is required to stall.
  - An entry freed by a fill in the same cycle is not reusable until the next cycle.
- Issue:
  - l2_req_valid=1 whenever any entry is in WAIT_ISSUE.
  - Selected entry: the lowest-index WAIT_ISSUE entry. req_addr, req_op and req_id are driven from registered state (combinational from state, no input paths).
  - Request fields hold stable while valid=1 and ready=0. A higher-priority entry may not preempt a pending request; the selection locks until accepted.
  - On valid&&ready the entry moves to WAIT_FILL at the edge.
  - An entry allocated at edge N is first visible on l2_req at cycle N+1.
- Fill:
  - l2_fill_valid with l2_fill_id in WAIT_FILL (state at start of cycle) moves that entry to IDLE at the edge.
  - On the same edge, fill_valid=1 for exactly one cycle, with that entry's addr, way and op.
  - A fill to an entry not in WAIT_FILL is ignored and fill_valid stays 0.
  - When there is no valid fill, fill_valid=0 and fill_addr/way/op hold their previous values.
- Lookup:
  - mshr_hit = lookup_valid && any non-IDLE entry whose addr == lookup_addr. It uses registered state only.
  - An entry being filled or allocated this cycle counts by its start-of-cycle state.
  - An allocation at edge N produces a hit for the same address from cycle N+1.
- Status outputs: full and occupancy are derived combinationally from registered state.
- Simultaneous alloc, issue-accept and fill on different entries all take effect on the same edge.

Test Plan:
- Reset, then alloc addr=0x100, way=4'b0010, op=1 → next cycle l2_req_valid=1, addr=0x100, op=3, id=0; occupancy=1; lookup 0x100 gives mshr_hit=1, lookup 0x104 gives 0.
- Hold l2_req_ready=0 for 5 cycles while allocating 0x200 (op=2) → request stays id=0 and stable. Raise ready → id=0 accepted; next cycle id=1, op=7.
- Allocate 4 distinct addresses → full=1, occupancy=4. A 5th alloc is dropped; occupancy stays 4 and no new request appears.
- Fill id=2 while entry 2 is in WAIT_FILL → next cycle fill_valid pulse with entry 2's addr/way/op; occupancy drops by 1. Same-cycle alloc while full is still dropped.
- Fill id=3 while entry 3 is in WAIT_ISSUE or IDLE → fill_valid stays 0 and the entry state is unchanged.
- Assert rst with 3 entries busy and a request pending → next cycle all outputs are 0. A subsequent fill id=0 produces no fill_valid.
